regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Scoreboard and write-port scheduler for the 32 x 32 integer register file. Tracks which architectural registers await a result from a long-latency unit (load/store unit, multiply/divide unit) and stalls issue on RAW/WAW hazards. Round-robin arbitrates the two completing units onto the register file's single write port. Sits between the decode/issue stage, the two long-latency units and the register file's `rd_addr_i` / `write_data_i` / `reg_write_en` inputs.

## Interface
- `XLEN`, 32: data width of write-back values.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue_valid_i`  in  1  decode presents an instruction this cycle.
- `issue_rs1_addr_i`, `issue_rs2_addr_i`, `issue_rd_addr_i`  in  5 each  source/destination register indices.
- `issue_uses_rs1_i`, `issue_uses_rs2_i`  in  1 each  the instruction reads rs1 / rs2.
- `issue_writes_i`  in  1  the instruction writes rd (any unit).
- `issue_long_i`  in  1  rd is produced later by a long-latency unit; meaningful only with `issue_writes_i`.
- `issue_stall_o`  out  1  combinational; instruction must be held, not accepted.
- `wb0_valid_i`, `wb1_valid_i`  in  1 each  LSU (0) / MDU (1) result ready.
- `wb0_rd_addr_i`, `wb1_rd_addr_i`  in  5 each  destination index.
- `wb0_data_i`, `wb1_data_i`  in  XLEN each  result value.
- `wb0_ready_o`, `wb1_ready_o`  out  1 each  combinational grant; a transfer occurs on a posedge with valid & ready.
- `rf_rd_addr_o`  out  5  registered, to register file `rd_addr_i`.
- `rf_write_data_o`  out  XLEN  registered, to register file `write_data_i`.
- `rf_write_en_o`  out  1  registered, to register file `reg_write_en`.
- `busy_o`  out  32  current scoreboard bit vector (debug/visibility).

## Operation
- State: `busy[31:0]`, a round-robin pointer `last_grant` (1 bit), and the write-port output registers.
- Stall: `issue_stall_o = issue_valid_i & ((uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes & busy[rd]))`. It is computed from registered `busy` only; there is no same-cycle bypass. `busy[0]` is always 0.
- Issue accept: `issue_valid_i & !issue_stall_o`. If also `issue_writes_i & issue_long_i & rd != 0`, then `busy[rd]` is set at that posedge. Short-latency writes never touch `busy`.
- Arbitration:
  - Only one valid: that unit is granted.
  - Both valid: the unit not equal to `last_grant` is granted.
  - `last_grant` updates to the granted unit on each transfer.
  - At most one ready is high per cycle, and ready is low when the unit is not valid.
- Transfer: the output registers load `{addr, data}` at the handshake edge. `rf_write_en_o` is 1 for exactly the following cycle, and is forced 0 when addr = 0. With no transfer, `rf_write_en_o` is 0 and addr/data hold.
- Busy clear: `busy[rf_rd_addr_o]` clears at the posedge that ends the cycle in which `rf_write_en_o` = 1. This guarantees the register file holds the new value before dependents unstall.
- Simultaneous set and clear of the same index on one edge: set wins. This is unreachable by construction (WAW stall) but must still be coded.
- A write-back to a register that is not busy is legal: it is written and `busy` is unchanged.

## Timing
- Reset (async assert, sync-safe release):
  - `busy` = 0, `last_grant` = 1 (so unit 0 wins the first contention).
  - `rf_write_en_o` = 0, `rf_rd_addr_o` = 0, `rf_write_data_o` = 0.
  - Stall and ready outputs follow their combinational definitions with `busy` = 0.
- Reset mid-operation discards all pending busy bits and any in-flight write (the enable drops immediately).
- Issue-to-busy: 1 edge. Write-back handshake to register file write enable: 1 edge. Handshake to busy clear: 2 edges. Earliest unstalled issue of a dependent instruction is in the cycle after the busy clear.
- Back-to-back transfers are allowed every cycle. Sustained contention alternates 0,1,0,1.

## Test plan
- Reset, then issue long load to rd=5 (`issue_valid`=1, `writes`=1, `long`=1) → `busy_o` = 0x0000_0020 after 1 edge; a following instruction with rs1=5 sees `issue_stall_o`=1.
- `wb0` valid, rd=5, data=0xDEADBEEF → `wb0_ready_o`=1; next cycle `rf_write_en_o`=1, `rf_rd_addr_o`=5, `rf_write_data_o`=0xDEADBEEF; one edge later `busy_o`=0 and the stall drops.
- Both units valid every cycle (rd=1/data=0xCAFEBABE vs rd=2/data=0x12345678) → grants alternate starting with unit 0; no data loss; each unit is held while not ready.
- Long issue to rd=0, then `wb1` rd=0 data=0xFFFFFFFF → `busy_o` stays 0, the handshake completes, `rf_write_en_o` stays 0.
- Long issue to rd=7 pending, then a short ALU write to rd=7 → `issue_stall_o`=1 (WAW) until busy[7] clears.
- Set busy[3] and busy[9], assert `rst` asynchronously mid-cycle with a transfer in flight → `busy_o`=0 and `rf_write_en_o`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Register-file scoreboard and write-port scheduler: tracks registers pending a long-latency
// result, stalls hazardous issue, and round-robins two completing units onto one write port.
module regfile_wb_scheduler #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rs1_addr_i,
    input  logic [4:0]      issue_rs2_addr_i,
    input  logic [4:0]      issue_rd_addr_i,
    input  logic            issue_uses_rs1_i,
    input  logic            issue_uses_rs2_i,
    input  logic            issue_writes_i,
    input  logic            issue_long_i,
    output logic            issue_stall_o,

    input  logic            wb0_valid_i,
    input  logic [4:0]      wb0_rd_addr_i,
    input  logic [XLEN-1:0] wb0_data_i,
    output logic            wb0_ready_o,

    input  logic            wb1_valid_i,
    input  logic [4:0]      wb1_rd_addr_i,
    input  logic [XLEN-1:0] wb1_data_i,
    output logic            wb1_ready_o,

    output logic [4:0]      rf_rd_addr_o,
    output logic [XLEN-1:0] rf_write_data_o,
    output logic            rf_write_en_o,

    output logic [31:0]     busy_o
);

    logic [31:0] busy_q, busy_d;
    logic        last_grant_q;
    logic        grant0, grant1;
    logic        issue_accept, set_busy;

    // Hazard check uses registered busy only; no bypass from the write port.
    always_comb begin
        issue_stall_o = issue_valid_i &
                        ((issue_uses_rs1_i & busy_q[issue_rs1_addr_i]) |
                         (issue_uses_rs2_i & busy_q[issue_rs2_addr_i]) |
                         (issue_writes_i   & busy_q[issue_rd_addr_i]));
        issue_accept  = issue_valid_i & ~issue_stall_o;
        set_busy      = issue_accept & issue_writes_i & issue_long_i & (issue_rd_addr_i != 5'd0);
    end

    // Under contention the unit that did not win last time is granted.
    always_comb begin
        grant0      = wb0_valid_i & (~wb1_valid_i | last_grant_q);
        grant1      = wb1_valid_i & (~wb0_valid_i | ~last_grant_q);
        wb0_ready_o = grant0;
        wb1_ready_o = grant1;
    end

    // Clear for the register just written, then set from issue so set wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (rf_write_en_o) begin
            busy_d[rf_rd_addr_o] = 1'b0;
        end
        if (set_busy) begin
            busy_d[issue_rd_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q          <= '0;
            last_grant_q    <= 1'b1;
            rf_rd_addr_o    <= '0;
            rf_write_data_o <= '0;
            rf_write_en_o   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (grant0) begin
                rf_rd_addr_o    <= wb0_rd_addr_i;
                rf_write_data_o <= wb0_data_i;
                rf_write_en_o   <= (wb0_rd_addr_i != 5'd0);
                last_grant_q    <= 1'b0;
            end else if (grant1) begin
                rf_rd_addr_o    <= wb1_rd_addr_i;
                rf_write_data_o <= wb1_data_i;
                rf_write_en_o   <= (wb1_rd_addr_i != 5'd0);
                last_grant_q    <= 1'b1;
            end else begin
                rf_write_en_o   <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: scoreboard set/clear, stalls, arbitration, reset.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        issue_valid, uses_rs1, uses_rs2, writes, long_op;
    logic [4:0]  rs1, rs2, rd;
    logic        stall;
    logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rf_en;
    logic [31:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_scheduler #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid_i    (issue_valid),
        .issue_rs1_addr_i (rs1),
        .issue_rs2_addr_i (rs2),
        .issue_rd_addr_i  (rd),
        .issue_uses_rs1_i (uses_rs1),
        .issue_uses_rs2_i (uses_rs2),
        .issue_writes_i   (writes),
        .issue_long_i     (long_op),
        .issue_stall_o    (stall),
        .wb0_valid_i      (wb0_valid),
        .wb0_rd_addr_i    (wb0_rd),
        .wb0_data_i       (wb0_data),
        .wb0_ready_o      (wb0_ready),
        .wb1_valid_i      (wb1_valid),
        .wb1_rd_addr_i    (wb1_rd),
        .wb1_data_i       (wb1_data),
        .wb1_ready_o      (wb1_ready),
        .rf_rd_addr_o     (rf_addr),
        .rf_write_data_o  (rf_data),
        .rf_write_en_o    (rf_en),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; uses_rs1 = 0; uses_rs2 = 0; writes = 0; long_op = 0;
        rs1 = 0; rs2 = 0; rd = 0;
        wb0_valid = 0; wb1_valid = 0; wb0_rd = 0; wb1_rd = 0; wb0_data = 0; wb1_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #2;
        issue_valid = 1; uses_rs1 = 1; rs1 = 5'd5; writes = 1; rd = 5'd5;
        wb0_valid = 1; wb1_valid = 1;
        #1;
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected %h", busy, 32'h0); end
        n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", rf_en); end
        n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", rf_addr); end
        n_checks++; if (rf_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rf_data); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (wb0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b expected 1", wb0_ready); end
        n_checks++; if (wb1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b expected 0", wb1_ready); end
        idle_inputs();
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic test_long_load();
        issue_valid = 1; writes = 1; long_op = 1; rd = 5'd5;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_issue_stall: got %b expected 0", stall); end
        tick();
        issue_valid = 1; writes = 0; long_op = 0; rd = 0; uses_rs1 = 1; rs1 = 5'd5;
        #1;
        n_checks++; if (busy !== 32'h0000_0020) begin n_fail++; $display("FAIL load_busy: got %h expected %h", busy, 32'h20); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_raw_stall: got %b expected 1", stall); end
    endtask

    // Dependent issue from test_long_load stays presented throughout.
    task automatic test_writeback();
        wb0_valid = 1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (wb0_ready !== 1'b1) begin n_fail++; $display("FAIL wb_ready0: got %b expected 1", wb0_ready); end
        n_checks++; if (wb1_ready !== 1'b0) begin n_fail++; $display("FAIL wb_ready1: got %b expected 0", wb1_ready); end
        tick();
        wb0_valid = 0;
        #1;
        n_checks++; if (rf_en !== 1'b1) begin n_fail++; $display("FAIL wb_en: got %b expected 1", rf_en); end
        n_checks++; if (rf_addr !== 5'd5) begin n_fail++; $display("FAIL wb_addr: got %h expected 05", rf_addr); end
        n_checks++; if (rf_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_data: got %h expected deadbeef", rf_data); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wb_stall_held: got %b expected 1", stall); end
        tick();
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL wb_busy_clear: got %h expected 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wb_stall_drop: got %b expected 0", stall); end
        n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL wb_en_drop: got %b expected 0", rf_en); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        do_reset();
        wb0_valid = 1; wb0_rd = 5'd1; wb0_data = 32'hCAFEBABE;
        wb1_valid = 1; wb1_rd = 5'd2; wb1_data = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (wb0_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL rr_ready0[%0d]: got %b expected %b", i, wb0_ready, (i % 2 == 0)); end
            n_checks++; if (wb1_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL rr_ready1[%0d]: got %b expected %b", i, wb1_ready, (i % 2 == 1)); end
            exp_addr = (i % 2 == 0) ? 5'd1 : 5'd2;
            exp_data = (i % 2 == 0) ? 32'hCAFEBABE : 32'h12345678;
            tick();
            n_checks++; if (rf_en !== 1'b1) begin n_fail++; $display("FAIL rr_en[%0d]: got %b expected 1", i, rf_en); end
            n_checks++; if (rf_addr !== exp_addr) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h expected %h", i, rf_addr, exp_addr); end
            n_checks++; if (rf_data !== exp_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, rf_data, exp_data); end
        end
        wb0_valid = 0; wb1_valid = 0;
        tick();
        n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL idle_en: got %b expected 0", rf_en); end
        n_checks++; if (rf_addr !== 5'd2) begin n_fail++; $display("FAIL idle_addr_hold: got %h expected 02", rf_addr); end
        n_checks++; if (rf_data !== 32'h12345678) begin n_fail++; $display("FAIL idle_data_hold: got %h expected 12345678", rf_data); end
    endtask

    task automatic test_rd_zero();
        issue_valid = 1; writes = 1; long_op = 1; rd = 5'd0;
        tick();
        issue_valid = 0; writes = 0; long_op = 0;
        #1;
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL rd0_busy: got %h expected 0", busy); end
        wb1_valid = 1; wb1_rd = 5'd0; wb1_data = 32'hFFFFFFFF;
        #1;
        n_checks++; if (wb1_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready1: got %b expected 1", wb1_ready); end
        tick();
        wb1_valid = 0;
        n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL rd0_en: got %b expected 0", rf_en); end
        n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL rd0_addr: got %h expected 0", rf_addr); end
        n_checks++; if (rf_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rd0_data: got %h expected ffffffff", rf_data); end
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL rd0_busy_after: got %h expected 0", busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_waw();
        issue_valid = 1; writes = 1; long_op = 1; rd = 5'd7;
        tick();
        long_op = 0;
        #1;
        n_checks++; if (busy !== 32'h0000_0080) begin n_fail++; $display("FAIL waw_busy: got %h expected 00000080", busy); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b expected 1", stall); end
        tick();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall_hold: got %b expected 1", stall); end
        wb0_valid = 1; wb0_rd = 5'd7; wb0_data = 32'h0000_0077;
        tick();
        wb0_valid = 0;
        #1;
        n_checks++; if (rf_en !== 1'b1) begin n_fail++; $display("FAIL waw_en: got %b expected 1", rf_en); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall_wb: got %b expected 1", stall); end
        tick();
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL waw_busy_clear: got %h expected 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_stall_drop: got %b expected 0", stall); end
        tick();
        idle_inputs();
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL waw_short_nobusy: got %h expected 0", busy); end
    endtask

    task automatic test_async_reset();
        issue_valid = 1; writes = 1; long_op = 1; rd = 5'd3;
        tick();
        rd = 5'd9;
        tick();
        issue_valid = 0; writes = 0; long_op = 0;
        #1;
        n_checks++; if (busy !== 32'h0000_0208) begin n_fail++; $display("FAIL arst_busy_set: got %h expected 00000208", busy); end
        wb1_valid = 1; wb1_rd = 5'd3; wb1_data = 32'h0000_0033;
        tick();
        wb1_valid = 0;
        #1;
        n_checks++; if (rf_en !== 1'b1) begin n_fail++; $display("FAIL arst_inflight_en: got %b expected 1", rf_en); end
        rst = 1;
        #1;
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL arst_busy: got %h expected 0", busy); end
        n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL arst_en: got %b expected 0", rf_en); end
        n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL arst_addr: got %h expected 0", rf_addr); end
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_long_load();
        test_writeback();
        test_back_to_back();
        test_rd_zero();
        test_waw();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
